// File: rtl/zeroriscy_ex_multdiv_iter_pkg.sv
// Shared types for the iterative EX-stage multiply/divide unit:
// operator encoding, FSM state encoding and a small decode helper.
package zeroriscy_ex_multdiv_iter_pkg;

    typedef enum logic [1:0] {
        MD_OP_MULL = 2'b00,
        MD_OP_MULH = 2'b01,
        MD_OP_DIV  = 2'b10,
        MD_OP_REM  = 2'b11
    } md_op_e;

    // Legacy state codes, kept stable so existing trace decoders still match.
    localparam logic [2:0] MD_ST_IDLE     = 3'd0;
    localparam logic [2:0] MD_ST_PREP     = 3'd1;
    localparam logic [2:0] MD_ST_MUL_ITER = 3'd2;
    localparam logic [2:0] MD_ST_DIV_ITER = 3'd3;
    localparam logic [2:0] MD_ST_FINISH   = 3'd4;

    typedef enum logic [2:0] {
        MD_IDLE     = MD_ST_IDLE,
        MD_PREP     = MD_ST_PREP,
        MD_MUL_ITER = MD_ST_MUL_ITER,
        MD_DIV_ITER = MD_ST_DIV_ITER,
        MD_FINISH   = MD_ST_FINISH
    } md_fsm_e;

    function automatic logic is_div_op(input md_op_e op);
        return (op == MD_OP_DIV) || (op == MD_OP_REM);
    endfunction

endpackage

// File: rtl/zeroriscy_ex_multdiv_iter_div_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract
// the divisor magnitude and keep the difference when it did not borrow.
module zeroriscy_div_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic [WIDTH-1:0] divisor_i,
    input  logic             dividend_bit_i,
    output logic [WIDTH-1:0] rem_o,
    output logic             quot_bit_o
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    assign shifted = {rem_i, dividend_bit_i};
    assign diff    = shifted - {1'b0, divisor_i};

    // rem_i < divisor keeps shifted below 2*divisor, so the top bit is a clean borrow flag.
    assign quot_bit_o = ~diff[WIDTH];
    assign rem_o      = quot_bit_o ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];

endmodule

// File: rtl/zeroriscy_ex_multdiv_iter.sv
// Iterative RV32M multiply/divide unit: magnitude shift-add multiplier
// (MUL_STEP bits per cycle) and restoring divider, with kill and held result.
module zeroriscy_ex_multdiv_iter
    import zeroriscy_ex_multdiv_iter_pkg::*;
#(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned MUL_STEP = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             mult_en_i,
    input  logic             div_en_i,
    input  logic [1:0]       operator_i,
    input  logic [1:0]       signed_mode_i,
    input  logic [WIDTH-1:0] op_a_i,
    input  logic [WIDTH-1:0] op_b_i,
    input  logic             kill_i,
    output logic             ready_o,
    output logic [WIDTH-1:0] result_o
);

    localparam int unsigned      CNT_W      = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] MUL_CYCLES = CNT_W'(WIDTH / MUL_STEP);
    localparam logic [CNT_W-1:0] DIV_CYCLES = CNT_W'(WIDTH);

    md_fsm_e            state_q, state_d;
    logic [CNT_W-1:0]   cnt_q;
    md_op_e             operator_q;
    logic [1:0]         signed_q;
    logic [WIDTH-1:0]   op_a_q, op_b_q;
    logic [WIDTH-1:0]   mag_a_q, mag_b_q;
    logic [2*WIDTH-1:0] acc_q;
    logic               sign_a_q, sign_b_q, div_zero_q;
    logic [WIDTH-1:0]   result_q;

    logic               active, start, abort, is_div;
    logic               sign_a_c, sign_b_c;
    logic [WIDTH-1:0]   mag_a_c, mag_b_c;
    logic [WIDTH+MUL_STEP-1:0] mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH-1:0]   div_rem;
    logic               div_qbit;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quot, rem, fin_result;

    assign active = mult_en_i | div_en_i;
    assign start  = active & ~kill_i;
    assign abort  = kill_i | ~active;
    assign is_div = is_div_op(operator_q);

    assign sign_a_c = op_a_q[WIDTH-1] & signed_q[0];
    assign sign_b_c = op_b_q[WIDTH-1] & signed_q[1];
    assign mag_a_c  = sign_a_c ? -op_a_q : op_a_q;
    assign mag_b_c  = sign_b_c ? -op_b_q : op_b_q;

    // Low half of acc holds the unretired multiplier bits; the high half accumulates.
    always_comb begin
        // NOTE: every variable written here gets a default first, so no path can infer a latch.
        mul_sum = {{MUL_STEP{1'b0}}, acc_q[2*WIDTH-1:WIDTH]};
        for (int j = 0; j < MUL_STEP; j++) begin
            if (acc_q[j]) begin
                mul_sum = mul_sum + ({{MUL_STEP{1'b0}}, mag_a_q} << j);
            end
        end
    end

    assign mul_next = {mul_sum, acc_q[WIDTH-1:MUL_STEP]};

    // Dividend bits leave the top of mag_a_q while quotient bits enter at the bottom.
    zeroriscy_div_step #(
        .WIDTH(WIDTH)
    ) u_div_step (
        .rem_i          (acc_q[WIDTH-1:0]),
        .divisor_i      (mag_b_q),
        .dividend_bit_i (mag_a_q[WIDTH-1]),
        .rem_o          (div_rem),
        .quot_bit_o     (div_qbit)
    );

    assign prod = (sign_a_q ^ sign_b_q) ? -acc_q : acc_q;
    assign quot = (sign_a_q ^ sign_b_q) ? -mag_a_q : mag_a_q;
    assign rem  = sign_a_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];

    always_comb begin
        fin_result = '0;
        if (div_zero_q) begin
            fin_result = (operator_q == MD_OP_REM) ? op_a_q : '1;
        end else begin
            case (operator_q)
                MD_OP_MULL: fin_result = prod[WIDTH-1:0];
                MD_OP_MULH: fin_result = prod[2*WIDTH-1:WIDTH];
                MD_OP_DIV:  fin_result = quot;
                default:    fin_result = rem;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        ready_o = 1'b0;
        case (state_q)
            MD_IDLE: begin
                ready_o = ~active;
                if (start) state_d = MD_PREP;
            end
            MD_PREP: begin
                if (abort)                         state_d = MD_IDLE;
                else if (is_div && op_b_q == '0)   state_d = MD_FINISH;
                else if (is_div)                   state_d = MD_DIV_ITER;
                else                               state_d = MD_MUL_ITER;
            end
            MD_MUL_ITER, MD_DIV_ITER: begin
                if (abort)                         state_d = MD_IDLE;
                else if (cnt_q == CNT_W'(1))       state_d = MD_FINISH;
            end
            MD_FINISH: begin
                ready_o = ~kill_i;
                state_d = MD_IDLE;
            end
            default: state_d = MD_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= MD_IDLE;
            cnt_q      <= '0;
            operator_q <= MD_OP_MULL;
            signed_q   <= '0;
            op_a_q     <= '0;
            op_b_q     <= '0;
            mag_a_q    <= '0;
            mag_b_q    <= '0;
            acc_q      <= '0;
            sign_a_q   <= 1'b0;
            sign_b_q   <= 1'b0;
            div_zero_q <= 1'b0;
            result_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q <= state_d;
            case (state_q)
                MD_IDLE: begin
                    if (start) begin
                        op_a_q     <= op_a_i;
                        op_b_q     <= op_b_i;
                        operator_q <= md_op_e'(operator_i);
                        signed_q   <= signed_mode_i;
                    end
                end
                MD_PREP: begin
                    cnt_q      <= is_div ? DIV_CYCLES : MUL_CYCLES;
                    sign_a_q   <= sign_a_c;
                    sign_b_q   <= sign_b_c;
                    mag_a_q    <= mag_a_c;
                    mag_b_q    <= mag_b_c;
                    acc_q      <= is_div ? '0 : {{WIDTH{1'b0}}, mag_b_c};
                    div_zero_q <= is_div && (op_b_q == '0);
                end
                MD_MUL_ITER: begin
                    acc_q <= mul_next;
                    cnt_q <= cnt_q - CNT_W'(1);
                end
                MD_DIV_ITER: begin
                    acc_q   <= {{WIDTH{1'b0}}, div_rem};
                    mag_a_q <= {mag_a_q[WIDTH-2:0], div_qbit};
                    cnt_q   <= cnt_q - CNT_W'(1);
                end
                MD_FINISH: begin
                    if (!kill_i) result_q <= fin_result;
                end
                default: ;
            endcase
        end
    end

    assign result_o = result_q;

endmodule
